// File: rtl/bp_regs_pkg.sv
// Shared constants for the Bus Pirate lane controller: register map,
// ID default, lane indices and the bus-cycle FSM state encoding.
package bp_regs_pkg;

   localparam logic [5:0] ADDR_OE       = 6'h00;
   localparam logic [5:0] ADDR_OD       = 6'h01;
   localparam logic [5:0] ADDR_DIR      = 6'h02;
   localparam logic [5:0] ADDR_DOUT     = 6'h03;
   localparam logic [5:0] ADDR_DIN      = 6'h04;
   localparam logic [5:0] ADDR_DOUT_SET = 6'h05;
   localparam logic [5:0] ADDR_DOUT_CLR = 6'h06;
   localparam logic [5:0] ADDR_ID       = 6'h07;
   localparam logic [5:0] ADDR_EDGE     = 6'h08;
   localparam logic [5:0] ADDR_EDGE_EN  = 6'h09;

   localparam logic [15:0] ID_VALUE_DEF = 16'hB9A1;

   localparam int LANE_MOSI  = 0;
   localparam int LANE_CLOCK = 1;
   localparam int LANE_MISO  = 2;
   localparam int LANE_CS    = 3;
   localparam int LANE_AUX   = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_READ     = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_e;

endpackage

// File: rtl/bp_sync.sv
// Multi-flop synchronizer for asynchronous inputs. WIDTH bits, STAGES deep,
// every stage resets to RESET_VAL so idle strobes read as inactive.
module bp_sync #(
   parameter int              WIDTH     = 1,
   parameter int              STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   // Shift chain: stage 0 samples the pin, each later stage its predecessor.
   always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Chain registers; the whole array is reset so no stage can leak a stale strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         // NOTE: non-blocking so each stage takes its predecessor's value from before this edge.
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mc_pin_ctrl.sv
// Register-mapped controller for the five Bus Pirate IO buffer lanes,
// driven by the MCU's asynchronous parallel memory bus.
// Optional feature: define MC_PIN_EDGE_IRQ_EN to build the EDGE/EDGE_EN
// registers and the edge interrupt; otherwise irq is tied low.
module mc_pin_ctrl
   import bp_regs_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          NUM_PINS    = 5,
   parameter logic [15:0] ID_VALUE    = ID_VALUE_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mc_ce_n,
   input  logic                mc_we_n,
   input  logic                mc_oe_n,
   input  logic [5:0]          mc_add,
   input  logic [15:0]         mc_din,
   output logic [15:0]         mc_dout,
   output logic                mc_dout_oe,
   output logic [NUM_PINS-1:0] pin_oe,
   output logic [NUM_PINS-1:0] pin_od,
   output logic [NUM_PINS-1:0] pin_dir,
   output logic [NUM_PINS-1:0] pin_dout,
   input  logic [NUM_PINS-1:0] pin_din,
   output logic                irq
);

   localparam int PAD = 16 - NUM_PINS;

   logic                ce_s, we_s, oe_s;
   logic [5:0]          add_s;
   logic [NUM_PINS-1:0] data_s;
   logic [NUM_PINS-1:0] din_s;
   logic                unused_din_hi;

   // Only the lane-wide slice of the write bus carries register bits.
   assign unused_din_hi = ^mc_din[15:NUM_PINS];

   bp_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RESET_VAL(3'b111)) u_sync_strobe (
      .clock (clock),
      .reset (reset),
      .d_i   ({mc_ce_n, mc_we_n, mc_oe_n}),
      .q_o   ({ce_s, we_s, oe_s})
   );

   bp_sync #(.WIDTH(6 + NUM_PINS), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_bus (
      .clock (clock),
      .reset (reset),
      .d_i   ({mc_add, mc_din[NUM_PINS-1:0]}),
      .q_o   ({add_s, data_s})
   );

   bp_sync #(.WIDTH(NUM_PINS), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_din (
      .clock (clock),
      .reset (reset),
      .d_i   (pin_din),
      .q_o   (din_s)
   );

   state_e              state_q, state_d;
   logic [5:0]          hold_add_q, hold_add_d;
   logic [NUM_PINS-1:0] hold_data_q, hold_data_d;
   logic [NUM_PINS-1:0] pin_oe_q, pin_oe_d, pin_od_q, pin_od_d;
   logic [NUM_PINS-1:0] pin_dir_q, pin_dir_d, pin_dout_q, pin_dout_d;
   logic [15:0]         rd_data_q, rd_data_d, rd_mux;
   logic                rd_oe_q, rd_oe_d;
   logic                wr_commit;

`ifdef MC_PIN_EDGE_IRQ_EN
   logic [NUM_PINS-1:0] edge_q, edge_d, edge_en_q, edge_en_d, din_prev_q, din_prev_d;
   logic                irq_q, irq_d;
`endif

   // Register read decode on the synchronized address.
   always_comb begin
      rd_mux = 16'h0000;
      case (add_s)
         ADDR_OE:      rd_mux = {{PAD{1'b0}}, pin_oe_q};
         ADDR_OD:      rd_mux = {{PAD{1'b0}}, pin_od_q};
         ADDR_DIR:     rd_mux = {{PAD{1'b0}}, pin_dir_q};
         ADDR_DOUT:    rd_mux = {{PAD{1'b0}}, pin_dout_q};
         ADDR_DIN:     rd_mux = {{PAD{1'b0}}, din_s};
         ADDR_ID:      rd_mux = ID_VALUE;
`ifdef MC_PIN_EDGE_IRQ_EN
         ADDR_EDGE:    rd_mux = {{PAD{1'b0}}, edge_q};
         ADDR_EDGE_EN: rd_mux = {{PAD{1'b0}}, edge_en_q};
`endif
         default:      rd_mux = 16'h0000;
      endcase
   end

   // Bus-cycle FSM next state, read capture and write commit.
   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d     = state_q;
      hold_add_d  = hold_add_q;
      hold_data_d = hold_data_q;
      pin_oe_d    = pin_oe_q;
      pin_od_d    = pin_od_q;
      pin_dir_d   = pin_dir_q;
      pin_dout_d  = pin_dout_q;
      rd_data_d   = rd_data_q;
      rd_oe_d     = rd_oe_q;
      wr_commit   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!ce_s && !we_s) begin
               state_d     = ST_WRITE;
               hold_add_d  = add_s;
               hold_data_d = data_s;
            end else if (!ce_s && !oe_s) begin
               state_d   = ST_READ;
               rd_data_d = rd_mux;
               rd_oe_d   = 1'b1;
            end
         end
         ST_WRITE: begin
            if (we_s || ce_s) begin
               wr_commit = 1'b1;
               state_d   = ST_WAIT_REL;
            end else begin
               hold_add_d  = add_s;
               hold_data_d = data_s;
            end
         end
         ST_READ: begin
            if (oe_s || ce_s) begin
               rd_oe_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_REL: begin
            if (ce_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_commit) begin
         case (hold_add_q)
            ADDR_OE:       pin_oe_d   = hold_data_q;
            ADDR_OD:       pin_od_d   = hold_data_q;
            ADDR_DIR:      pin_dir_d  = hold_data_q;
            ADDR_DOUT:     pin_dout_d = hold_data_q;
            ADDR_DOUT_SET: pin_dout_d = pin_dout_q | hold_data_q;
            ADDR_DOUT_CLR: pin_dout_d = pin_dout_q & ~hold_data_q;
            default:       ;
         endcase
      end
   end

   // FSM state, holding register, lane config and registered read outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_add_q  <= '0;
         hold_data_q <= '0;
         pin_oe_q    <= '0;
         pin_od_q    <= '0;
         pin_dir_q   <= '0;
         pin_dout_q  <= '0;
         rd_data_q   <= '0;
         rd_oe_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_add_q  <= hold_add_d;
         hold_data_q <= hold_data_d;
         pin_oe_q    <= pin_oe_d;
         pin_od_q    <= pin_od_d;
         pin_dir_q   <= pin_dir_d;
         pin_dout_q  <= pin_dout_d;
         rd_data_q   <= rd_data_d;
         rd_oe_q     <= rd_oe_d;
      end
   end

`ifdef MC_PIN_EDGE_IRQ_EN
   // Edge capture: W1C clear first, then fresh edges OR in so a coincident edge survives.
   always_comb begin
      edge_d     = edge_q;
      edge_en_d  = edge_en_q;
      din_prev_d = din_s;
      if (wr_commit && hold_add_q == ADDR_EDGE)    edge_d    = edge_q & ~hold_data_q;
      if (wr_commit && hold_add_q == ADDR_EDGE_EN) edge_en_d = hold_data_q;
      edge_d = edge_d | (din_s ^ din_prev_q);
      irq_d  = |(edge_q & edge_en_q);
   end

   // Edge, enable and interrupt registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         edge_q     <= '0;
         edge_en_q  <= '0;
         din_prev_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         edge_q     <= edge_d;
         edge_en_q  <= edge_en_d;
         din_prev_q <= din_prev_d;
         irq_q      <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign mc_dout    = rd_data_q;
   assign mc_dout_oe = rd_oe_q;
   assign pin_oe     = pin_oe_q;
   assign pin_od     = pin_od_q;
   assign pin_dir    = pin_dir_q;
   assign pin_dout   = pin_dout_q;

endmodule

// File: tb/tb_mc_pin_ctrl.sv
// Directed bench for mc_pin_ctrl: bus writes/reads through the synchronizers,
// strobe-to-output latency, W1S/W1C, reset mid-transaction and the edge IRQ.
module tb_mc_pin_ctrl;
   import bp_regs_pkg::*;

   localparam int SS = 2;
   localparam int NP = 5;

   logic          clock;
   logic          reset;
   logic          mc_ce_n, mc_we_n, mc_oe_n;
   logic [5:0]    mc_add;
   logic [15:0]   mc_din;
   logic [15:0]   mc_dout;
   logic          mc_dout_oe;
   logic [NP-1:0] pin_oe, pin_od, pin_dir, pin_dout, pin_din;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;

   mc_pin_ctrl #(.SYNC_STAGES(SS), .NUM_PINS(NP), .ID_VALUE(16'hB9A1)) dut (
      .clock      (clock),
      .reset      (reset),
      .mc_ce_n    (mc_ce_n),
      .mc_we_n    (mc_we_n),
      .mc_oe_n    (mc_oe_n),
      .mc_add     (mc_add),
      .mc_din     (mc_din),
      .mc_dout    (mc_dout),
      .mc_dout_oe (mc_dout_oe),
      .pin_oe     (pin_oe),
      .pin_od     (pin_od),
      .pin_dir    (pin_dir),
      .pin_dout   (pin_dout),
      .pin_din    (pin_din),
      .irq        (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_reset();
      reset   = 1'b1;
      mc_ce_n = 1'b1;
      mc_we_n = 1'b1;
      mc_oe_n = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (4) @(posedge clock);
   endtask

   // Full write cycle; tgl is XORed into pin_din on the same edge that we_n rises.
   task automatic bus_write(input logic [5:0] a, input logic [15:0] d, input logic [NP-1:0] tgl);
      @(posedge clock);
      #1;
      mc_add  = a;
      mc_din  = d;
      mc_ce_n = 1'b0;
      mc_we_n = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      mc_we_n = 1'b1;
      mc_ce_n = 1'b1;
      pin_din = pin_din ^ tgl;
      repeat (6) @(posedge clock);
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
      @(posedge clock);
      #1;
      mc_add  = a;
      mc_ce_n = 1'b0;
      mc_oe_n = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      d = mc_dout;
      @(posedge clock);
      #1;
      mc_oe_n = 1'b1;
      mc_ce_n = 1'b1;
      repeat (6) @(posedge clock);
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      apply_reset();
      @(negedge clock);
      n_cmp++; if (pin_oe !== 5'b0)   begin n_err++; $display("FAIL reset_pin_oe: got %b want %b", pin_oe, 5'b0); end
      n_cmp++; if (pin_od !== 5'b0)   begin n_err++; $display("FAIL reset_pin_od: got %b want %b", pin_od, 5'b0); end
      n_cmp++; if (pin_dir !== 5'b0)  begin n_err++; $display("FAIL reset_pin_dir: got %b want %b", pin_dir, 5'b0); end
      n_cmp++; if (pin_dout !== 5'b0) begin n_err++; $display("FAIL reset_pin_dout: got %b want %b", pin_dout, 5'b0); end
      n_cmp++; if (mc_dout_oe !== 1'b0) begin n_err++; $display("FAIL reset_dout_oe: got %b want 0", mc_dout_oe); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
      bus_read(ADDR_ID, rd);
      n_cmp++; if (rd !== 16'hB9A1) begin n_err++; $display("FAIL read_id: got %h want %h", rd, 16'hB9A1); end
   endtask

   // Write OE and confirm the lanes change exactly SS+1 edges after we_n rises.
   task automatic test_write_latency();
      logic [15:0] rd;
      @(posedge clock);
      #1;
      mc_add  = ADDR_OE;
      mc_din  = 16'h0015;
      mc_ce_n = 1'b0;
      mc_we_n = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      mc_we_n = 1'b1;
      mc_ce_n = 1'b1;
      repeat (SS) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (pin_oe !== 5'b00000) begin n_err++; $display("FAIL oe_early: got %b want %b", pin_oe, 5'b00000); end
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (pin_oe !== 5'b10101) begin n_err++; $display("FAIL oe_on_time: got %b want %b", pin_oe, 5'b10101); end
      repeat (4) @(posedge clock);
      bus_read(ADDR_OE, rd);
      n_cmp++; if (rd !== 16'h0015) begin n_err++; $display("FAIL read_oe: got %h want %h", rd, 16'h0015); end
      bus_write(ADDR_DIR, 16'hFFEA, 5'b0);
      n_cmp++; if (pin_dir !== 5'b01010) begin n_err++; $display("FAIL write_dir: got %b want %b", pin_dir, 5'b01010); end
      bus_write(6'h3F, 16'h001F, 5'b0);
      n_cmp++; if (pin_oe !== 5'b10101 || pin_dir !== 5'b01010)
         begin n_err++; $display("FAIL ignored_write: got oe=%b dir=%b want oe=10101 dir=01010", pin_oe, pin_dir); end
   endtask

   task automatic test_set_clr();
      logic [15:0] rd;
      bus_write(ADDR_DOUT, 16'h0003, 5'b0);
      n_cmp++; if (pin_dout !== 5'b00011) begin n_err++; $display("FAIL dout_write: got %b want %b", pin_dout, 5'b00011); end
      bus_write(ADDR_DOUT_SET, 16'h0004, 5'b0);
      n_cmp++; if (pin_dout !== 5'b00111) begin n_err++; $display("FAIL dout_set: got %b want %b", pin_dout, 5'b00111); end
      bus_write(ADDR_DOUT_CLR, 16'h0001, 5'b0);
      n_cmp++; if (pin_dout !== 5'b00110) begin n_err++; $display("FAIL dout_clr: got %b want %b", pin_dout, 5'b00110); end
      bus_read(ADDR_DOUT_SET, rd);
      n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL read_dout_set: got %h want 0000", rd); end
      bus_read(ADDR_DOUT, rd);
      n_cmp++; if (rd !== 16'h0006) begin n_err++; $display("FAIL read_dout: got %h want 0006", rd); end
   endtask

   task automatic test_din();
      logic [15:0] rd;
      pin_din = 5'b01001;
      repeat (4) @(posedge clock);
      bus_read(ADDR_DIN, rd);
      n_cmp++; if (rd !== 16'h0009) begin n_err++; $display("FAIL read_din: got %h want 0009", rd); end
   endtask

   // Read of an unmapped address with dout_oe assert/deassert latency.
   task automatic test_read_timing();
      @(posedge clock);
      #1;
      mc_add  = 6'h3F;
      mc_ce_n = 1'b0;
      mc_oe_n = 1'b0;
      repeat (SS) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (mc_dout_oe !== 1'b0) begin n_err++; $display("FAIL dout_oe_early: got %b want 0", mc_dout_oe); end
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (mc_dout_oe !== 1'b1) begin n_err++; $display("FAIL dout_oe_assert: got %b want 1", mc_dout_oe); end
      n_cmp++; if (mc_dout !== 16'h0000) begin n_err++; $display("FAIL read_unmapped: got %h want 0000", mc_dout); end
      repeat (3) @(posedge clock);
      #1;
      mc_oe_n = 1'b1;
      mc_ce_n = 1'b1;
      repeat (SS) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (mc_dout_oe !== 1'b1) begin n_err++; $display("FAIL dout_oe_hold: got %b want 1", mc_dout_oe); end
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (mc_dout_oe !== 1'b0) begin n_err++; $display("FAIL dout_oe_release: got %b want 0", mc_dout_oe); end
      repeat (4) @(posedge clock);
   endtask

   task automatic test_reset_mid_txn();
      // Reset while READ is driving the bus.
      @(posedge clock);
      #1;
      mc_add  = ADDR_ID;
      mc_ce_n = 1'b0;
      mc_oe_n = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (mc_dout_oe !== 1'b1) begin n_err++; $display("FAIL pre_reset_dout_oe: got %b want 1", mc_dout_oe); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (mc_dout_oe !== 1'b0) begin n_err++; $display("FAIL reset_async_dout_oe: got %b want 0", mc_dout_oe); end
      mc_oe_n = 1'b1;
      mc_ce_n = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (4) @(posedge clock);
      // Reset while WRITE is still capturing: the write must not land.
      #1;
      mc_add  = ADDR_OD;
      mc_din  = 16'h001F;
      mc_ce_n = 1'b0;
      mc_we_n = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset   = 1'b1;
      mc_we_n = 1'b1;
      mc_ce_n = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (8) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (pin_od !== 5'b00000) begin n_err++; $display("FAIL reset_mid_write: got %b want %b", pin_od, 5'b00000); end
   endtask

`ifdef MC_PIN_EDGE_IRQ_EN
   task automatic test_edge_irq();
      logic [15:0] rd;
      bus_write(ADDR_EDGE, 16'h001F, 5'b0);
      bus_write(ADDR_EDGE_EN, 16'h0001, 5'b0);
      @(negedge clock);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b want 0", irq); end
      @(posedge clock);
      #1 pin_din[LANE_MOSI] = ~pin_din[LANE_MOSI];
      repeat (6) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_on_edge: got %b want 1", irq); end
      bus_write(ADDR_EDGE, 16'h0001, 5'b0);
      @(negedge clock);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_clear: got %b want 0", irq); end
      @(posedge clock);
      #1 pin_din[LANE_MOSI] = ~pin_din[LANE_MOSI];
      repeat (6) @(posedge clock);
      bus_write(ADDR_EDGE, 16'h0001, 5'b00001);
      bus_read(ADDR_EDGE, rd);
      n_cmp++; if (rd[0] !== 1'b1) begin n_err++; $display("FAIL edge_set_wins: got %b want 1", rd[0]); end
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", irq); end
   endtask
`else
   task automatic test_no_edge();
      logic [15:0] rd;
      bus_write(ADDR_EDGE_EN, 16'h001F, 5'b0);
      @(posedge clock);
      #1 pin_din = pin_din ^ 5'b11111;
      repeat (6) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_tied: got %b want 0", irq); end
      bus_read(ADDR_EDGE_EN, rd);
      n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL read_edge_en_absent: got %h want 0000", rd); end
   endtask
`endif

   initial begin
      reset   = 1'b1;
      mc_ce_n = 1'b1;
      mc_we_n = 1'b1;
      mc_oe_n = 1'b1;
      mc_add  = '0;
      mc_din  = '0;
      pin_din = '0;
      test_reset();
      test_write_latency();
      test_set_clr();
      test_din();
      test_read_timing();
      test_reset_mid_txn();
`ifdef MC_PIN_EDGE_IRQ_EN
      test_edge_irq();
`else
      test_no_edge();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
